// File: rtl/conv_acc_pkg.sv
// ============================================================================
// Module      : conv_acc_pkg
// Description : Shared defaults, lane-vector type and sizing helper for the
//               convolution accumulator path (packer and adder tree).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_acc_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_INPUT_NUM = 4;

    typedef logic [DEFAULT_INPUT_NUM-1:0][DEFAULT_WIDTH-1:0] lane_vec_t;

    // Width needed to hold a lane count in the range 0..lanes inclusive.
    function automatic int lane_cnt_w(input int lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tree_input_packer.sv
// ============================================================================
// Module      : tree_input_packer
// Description : Serial-to-parallel packer feeding the adder tree; collects
//               INPUT_NUM operands into one registered lane vector.
//               Optional build macro: PACKER_FLUSH_EN (in_last closes a
//               partial vector early).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tree_input_packer
    import conv_acc_pkg::*;
#(
    parameter int    WIDTH     = DEFAULT_WIDTH,
    parameter int    INPUT_NUM = DEFAULT_INPUT_NUM,
    localparam int   CNT_W     = $clog2(INPUT_NUM),
    localparam int   LANES_W   = lane_cnt_w(INPUT_NUM)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [WIDTH-1:0]                  in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_last,
    output logic [INPUT_NUM-1:0][WIDTH-1:0]   out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES_W-1:0]                out_lanes,
    output logic                              out_last
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(INPUT_NUM - 1);

    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [INPUT_NUM-2:0][WIDTH-1:0]   fill_q, fill_d;
    logic [INPUT_NUM-1:0][WIDTH-1:0]   out_data_q, out_data_d;
    logic                              out_valid_q, out_valid_d;
    logic [LANES_W-1:0]                out_lanes_q, out_lanes_d;
    logic                              out_last_q, out_last_d;

    logic [INPUT_NUM-1:0][WIDTH-1:0]   w_vec;
    logic                              w_last;
    logic                              w_fill_open;
    logic                              w_accept;
    logic                              w_close;
    logic                              w_xfer;

`ifdef PACKER_FLUSH_EN
    assign w_last = in_last;
`else
    logic w_unused_last;
    assign w_unused_last = in_last;
    assign w_last        = 1'b0;
`endif

    // The word can go to the fill buffer unless it is the one closing the vector.
    assign w_fill_open = (cnt_q != CNT_MAX) && !w_last;
    assign in_ready    = w_fill_open || !out_valid_q || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_close     = w_accept && !w_fill_open;
    assign w_xfer      = out_valid_q && out_ready;

    // Closing vector: stored lanes below cnt, the live word at cnt, zeros above.
    always_comb begin
        w_vec = '0;
        for (int i = 0; i < INPUT_NUM - 1; i++) begin
            if (CNT_W'(i) < cnt_q) begin
                w_vec[i] = fill_q[i];
            end
        end
        for (int i = 0; i < INPUT_NUM; i++) begin
            if (CNT_W'(i) == cnt_q) begin
                w_vec[i] = in_data;
            end
        end
    end

    always_comb begin
        fill_d = fill_q;
        cnt_d  = cnt_q;
        if (w_close) begin
            cnt_d = '0;
        end else if (w_accept) begin
            cnt_d = cnt_q + CNT_W'(1);
            for (int i = 0; i < INPUT_NUM - 1; i++) begin
                if (CNT_W'(i) == cnt_q) begin
                    fill_d[i] = in_data;
                end
            end
        end
    end

    // A close can only happen when the slot is free, so load wins over drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_lanes_d = out_lanes_q;
        out_last_d  = out_last_q;
        if (w_close) begin
            out_valid_d = 1'b1;
            out_data_d  = w_vec;
            out_lanes_d = LANES_W'(cnt_q) + LANES_W'(1);
            out_last_d  = w_last;
        end else if (w_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            fill_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            fill_q <= fill_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lanes_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_lanes_q <= out_lanes_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lanes = out_lanes_q;
    assign out_last  = out_last_q;

endmodule

`default_nettype wire

// File: tb/tb_tree_input_packer.sv
// ============================================================================
// Module      : tb_tree_input_packer
// Description : Self-checking bench for tree_input_packer (WIDTH=32,
//               INPUT_NUM=4); queue-based model plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tree_input_packer;

    localparam int W = 32;
    localparam int N = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [W-1:0]          in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;
    logic [N-1:0][W-1:0]   out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [2:0]            out_lanes;
    logic                  out_last;

    always #5 clk = ~clk;

    tree_input_packer #(.WIDTH(W), .INPUT_NUM(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_lanes (out_lanes),
        .out_last  (out_last)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mkvec(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // ---------------- reference model ----------------
    logic [31:0]  m_fill[$];
    logic [127:0] m_vec[$];
    int           m_lanes[$];
    bit           m_last[$];
    int           acc_words = 0;

    function automatic bit m_early();
`ifdef PACKER_FLUSH_EN
        return in_last;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_ready();
        return (m_fill.size() != N - 1 && !m_early()) || m_vec.size() == 0 || out_ready;
    endfunction

    always @(posedge clk) begin
        bit           acc;
        bit           closing;
        logic [127:0] v;
        if (rst) begin
            m_fill.delete();
            m_vec.delete();
            m_lanes.delete();
            m_last.delete();
        end else begin
            acc     = in_valid && exp_ready();
            closing = m_early();
            if (m_vec.size() != 0 && out_ready) begin
                void'(m_vec.pop_front());
                void'(m_lanes.pop_front());
                void'(m_last.pop_front());
            end
            if (acc) begin
                acc_words++;
                m_fill.push_back(in_data);
                if (m_fill.size() == N || closing) begin
                    v = '0;
                    foreach (m_fill[i]) v[i*32 +: 32] = m_fill[i];
                    m_vec.push_back(v);
                    m_lanes.push_back(m_fill.size());
                    m_last.push_back(closing);
                    m_fill.delete();
                end
            end
        end
    end

    // ---------------- compare process ----------------
    logic [127:0] seen[$];
    bit           stall_prev = 1'b0;
    logic [127:0] prev_data;
    logic [2:0]   prev_lanes;
    logic         prev_last;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            chk("in_ready", in_ready, exp_ready());
            chk("out_valid", out_valid, m_vec.size() != 0);
            if (m_vec.size() != 0) begin
                chk("out_data", out_data, m_vec[0]);
                chk("out_lanes", out_lanes, m_lanes[0]);
                chk("out_last", out_last, m_last[0]);
            end
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, prev_data);
                chk("stall_lanes", out_lanes, prev_lanes);
                chk("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) seen.push_back(out_data);
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_lanes = out_lanes;
            prev_last  = out_last;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input bit last);
        bit r;
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) return;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: word %0h not accepted within 200 cycles", w);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        int c0;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, '0);
        chk("reset_out_lanes", out_lanes, 3'd0);
        chk("reset_out_last", out_last, 1'b0);

        // 1: first vector
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(i, 1'b0);
        idle();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_data", out_data, mkvec(1, 2, 3, 4));
        chk("t1_lanes", out_lanes, 3'd4);
        tick();
        chk("t1_drained", out_valid, 1'b0);

        // 2: gapless stream
        seen.delete();
        c0 = cyc;
        for (int i = 1; i <= 12; i++) send(i, 1'b0);
        chk("t2_cycles", cyc - c0, 12);
        idle();
        tick();
        tick();
        chk("t2_count", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("t2_vec0", seen[0], mkvec(1, 2, 3, 4));
            chk("t2_vec1", seen[1], mkvec(5, 6, 7, 8));
            chk("t2_vec2", seen[2], mkvec(9, 10, 11, 12));
        end

        // 3: backpressure
        out_ready = 1'b0;
        seen.delete();
        c0 = cyc;
        for (int i = 1; i <= 7; i++) send(i, 1'b0);
        chk("t3_cycles", cyc - c0, 7);
        in_valid = 1'b1;
        in_data  = 8;
        @(negedge clk);
        chk("t3_stalled", in_ready, 1'b0);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_released", in_ready, 1'b1);
        tick();
        idle();
        chk("t3_vec0", seen.size() > 0 ? seen[0] : '0, mkvec(1, 2, 3, 4));
        chk("t3_valid", out_valid, 1'b1);
        chk("t3_data", out_data, mkvec(5, 6, 7, 8));
        tick();

        // 4: reset mid-vector with held output
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(i, 1'b0);
        send(10, 1'b0);
        send(11, 1'b0);
        idle();
        rst = 1'b1;
        #1;
        chk("t4_valid", out_valid, 1'b0);
        chk("t4_data", out_data, '0);
        chk("t4_lanes", out_lanes, 3'd0);
        chk("t4_ready", in_ready, 1'b1);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 20; i <= 23; i++) send(i, 1'b0);
        idle();
        chk("t4_new_data", out_data, mkvec(20, 21, 22, 23));
        chk("t4_new_lanes", out_lanes, 3'd4);
        tick();

`ifdef PACKER_FLUSH_EN
        // 5: early close
        send(7, 1'b0);
        send(8, 1'b1);
        idle();
        chk("t5_data", out_data, mkvec(7, 8, 0, 0));
        chk("t5_lanes", out_lanes, 3'd2);
        chk("t5_last", out_last, 1'b1);
        for (int i = 1; i <= 4; i++) send(i, 1'b0);
        idle();
        chk("t5_full_data", out_data, mkvec(1, 2, 3, 4));
        chk("t5_full_last", out_last, 1'b0);
        tick();
`endif

        // 6: random traffic
        c0 = acc_words;
        for (int k = 0; k < 60000 && acc_words < c0 + 10000; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        chk("t6_words_done", acc_words >= c0 + 10000, 1'b1);
        idle();
        out_ready = 1'b1;
        tick();
        tick();
        chk("t6_drained", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
